// File: rtl/mips_pkg.sv
// Shared constants, field positions and helpers for the MIPS pipeline front end.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [5:0]  MUXCOND_LOAD = 6'd1;
    localparam logic [5:0]  MUXCOND_HOLD = 6'd0;
    localparam logic [31:0] PC_STEP      = 32'd4;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // What the front end does this cycle, in priority order hold > jump > stall > run.
    typedef enum logic [1:0] {
        FE_RUN   = 2'd0,
        FE_STALL = 2'd1,
        FE_JUMP  = 2'd2,
        FE_HOLD  = 2'd3
    } fe_action_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/if_id_frontend_if.sv
// Instruction memory port: the front end drives the fetch address, memory returns the word combinationally.
interface if_id_frontend_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard detector: EX load writes a register that the ID instruction may read.
module load_use_detect (
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    output logic       hazard
);
    // rt is compared even for I-type instructions that only write it; stalling there is harmless.
    assign hazard = id_valid && ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));
endmodule

// File: rtl/if_id_frontend.sv
// MIPS IF stage + IF/ID register + ID decode with load-use stall and jump flush.
// Optional hazard statistics counters when IF_ID_HAZARD_STATS_EN is defined.
module if_id_frontend
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    if_id_frontend_if.master    imem,
    input  logic                ext_hold,
    input  logic                ex_jump,
    input  logic [31:0]         ex_jump_target,
    input  logic                ex_memread,
    input  logic [4:0]          ex_rt,
    output logic                ifid_valid,
    output logic [31:0]         ifid_pc4,
    output logic [5:0]          id_opcode,
    output logic [4:0]          id_rs,
    output logic [4:0]          id_rt,
    output logic [4:0]          id_rd,
    output logic [4:0]          id_shamt,
    output logic [5:0]          id_funct,
    output logic [31:0]         id_imm_ext,
    output logic                ctrl_bubble,
    output logic [5:0]          idex_muxcond,
    output logic                stall,
    output logic                flush
`ifdef IF_ID_HAZARD_STATS_EN
    ,
    output logic [31:0]         stall_count,
    output logic [31:0]         flush_count
`endif
);

    logic [31:0] pc_q;
    logic [31:0] ifid_instr_q;
    logic [31:0] ifid_pc4_q;
    logic        ifid_valid_q;
    logic [31:0] pc_plus4;
    logic        hazard;
    fe_action_e  action;

    assign pc_plus4       = pc_q + PC_STEP;
    assign imem.imem_addr = pc_q;

    assign ifid_valid = ifid_valid_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign id_opcode  = ifid_instr_q[OPCODE_MSB:OPCODE_LSB];
    assign id_rs      = ifid_instr_q[RS_MSB:RS_LSB];
    assign id_rt      = ifid_instr_q[RT_MSB:RT_LSB];
    assign id_rd      = ifid_instr_q[RD_MSB:RD_LSB];
    assign id_shamt   = ifid_instr_q[SHAMT_MSB:SHAMT_LSB];
    assign id_funct   = ifid_instr_q[FUNCT_MSB:FUNCT_LSB];
    assign id_imm_ext = sign_ext16(ifid_instr_q[IMM_MSB:IMM_LSB]);

    load_use_detect u_load_use_detect (
        .id_valid   (ifid_valid_q),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .hazard     (hazard)
    );

    always_comb begin
        action = FE_RUN;
        if (ext_hold)
            action = FE_HOLD;
        else if (ex_jump)
            action = FE_JUMP;
        else if (hazard)
            action = FE_STALL;
    end

    always_comb begin
        idex_muxcond = MUXCOND_LOAD;
        ctrl_bubble  = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        case (action)
            FE_HOLD: idex_muxcond = MUXCOND_HOLD;
            FE_JUMP: begin
                ctrl_bubble = 1'b1;
                flush       = 1'b1;
            end
            FE_STALL: begin
                ctrl_bubble = 1'b1;
                stall       = 1'b1;
            end
            default: ctrl_bubble = !ifid_valid_q;
        endcase
    end

    // On a jump the IF/ID PC+4 is left as is; it is meaningless while the slot is invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
        end else begin
            case (action)
                FE_JUMP: begin
                    pc_q         <= ex_jump_target;
                    ifid_instr_q <= NOP_INSTR;
                    ifid_valid_q <= 1'b0;
                end
                FE_RUN: begin
                    pc_q         <= pc_plus4;
                    ifid_instr_q <= imem.imem_rdata;
                    ifid_pc4_q   <= pc_plus4;
                    ifid_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef IF_ID_HAZARD_STATS_EN
    // stall/flush are already forced low under ext_hold, so hold needs no extra gating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= 32'h0;
            flush_count <= 32'h0;
        end else begin
            if (stall && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
            if (flush && (flush_count != 32'hFFFF_FFFF))
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_frontend.sv
// Self-checking bench for if_id_frontend: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the front end.
module tb_if_id_frontend;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ext_hold, ex_jump, ex_memread;
    logic [31:0] ex_jump_target;
    logic [4:0]  ex_rt;
    logic        ifid_valid, ctrl_bubble, stall, flush;
    logic [31:0] ifid_pc4, id_imm_ext;
    logic [5:0]  id_opcode, id_funct, idex_muxcond;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;

    logic        w_zero;
    logic [31:0] w_zero32;
    logic [4:0]  w_zero5;
    logic        w_valid, w_bubble, w_stall, w_flush;
    logic [31:0] w_pc4, w_imm;
    logic [5:0]  w_opcode, w_funct, w_muxcond;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
`ifdef IF_ID_HAZARD_STATS_EN
    logic [31:0] stall_count, flush_count, w_stall_count, w_flush_count;
`endif

    logic [31:0] imem [256];

    if_id_frontend_if imem_bus ();
    if_id_frontend_if imem_w ();
    assign imem_bus.imem_rdata = imem[imem_bus.imem_addr[9:2]];
    assign imem_w.imem_rdata   = imem[imem_w.imem_addr[9:2]];

    if_id_frontend #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem(imem_bus),
        .ext_hold(ext_hold), .ex_jump(ex_jump), .ex_jump_target(ex_jump_target),
        .ex_memread(ex_memread), .ex_rt(ex_rt),
        .ifid_valid(ifid_valid), .ifid_pc4(ifid_pc4),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .id_funct(id_funct), .id_imm_ext(id_imm_ext),
        .ctrl_bubble(ctrl_bubble), .idex_muxcond(idex_muxcond),
        .stall(stall), .flush(flush)
`ifdef IF_ID_HAZARD_STATS_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    if_id_frontend #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem(imem_w),
        .ext_hold(w_zero), .ex_jump(w_zero), .ex_jump_target(w_zero32),
        .ex_memread(w_zero), .ex_rt(w_zero5),
        .ifid_valid(w_valid), .ifid_pc4(w_pc4),
        .id_opcode(w_opcode), .id_rs(w_rs), .id_rt(w_rt), .id_rd(w_rd),
        .id_shamt(w_shamt), .id_funct(w_funct), .id_imm_ext(w_imm),
        .ctrl_bubble(w_bubble), .idex_muxcond(w_muxcond),
        .stall(w_stall), .flush(w_flush)
`ifdef IF_ID_HAZARD_STATS_EN
        , .stall_count(w_stall_count), .flush_count(w_flush_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    // Reference model: architectural view of the fetch slot and the decode slot.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    int unsigned m_stalls, m_flushes;
    logic        e_stall, e_flush, e_bubble;
    logic [5:0]  e_muxcond;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_stalls = 0; m_flushes = 0;
    endtask

    function automatic logic model_hazard();
        logic [4:0] rs, rt;
        rs = m_instr[25:21];
        rt = m_instr[20:16];
        return m_valid && ex_memread && ex_rt != 0 && (ex_rt == rs || ex_rt == rt);
    endfunction

    task automatic compute_expect();
        e_stall = 0; e_flush = 0; e_bubble = 0; e_muxcond = 6'd1;
        if (ext_hold) e_muxcond = 6'd0;
        else if (ex_jump) begin e_flush = 1; e_bubble = 1; end
        else if (model_hazard()) begin e_stall = 1; e_bubble = 1; end
        else e_bubble = !m_valid;
    endtask

    task automatic model_advance();
        if (ext_hold) return;
        if (ex_jump) begin
            m_flushes++;
            m_pc = ex_jump_target; m_instr = 32'h0; m_valid = 1'b0;
        end else if (model_hazard()) begin
            m_stalls++;
        end else begin
            m_instr = imem[m_pc[9:2]];
            m_pc4   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
        end
    endtask

    task automatic check_all();
        compute_expect();
        check("imem_addr", imem_bus.imem_addr, m_pc);
        check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
        check("ifid_pc4", ifid_pc4, m_pc4);
        check("id_opcode", {26'b0, id_opcode}, {26'b0, m_instr[31:26]});
        check("id_rs", {27'b0, id_rs}, {27'b0, m_instr[25:21]});
        check("id_rt", {27'b0, id_rt}, {27'b0, m_instr[20:16]});
        check("id_rd", {27'b0, id_rd}, {27'b0, m_instr[15:11]});
        check("id_shamt", {27'b0, id_shamt}, {27'b0, m_instr[10:6]});
        check("id_funct", {26'b0, id_funct}, {26'b0, m_instr[5:0]});
        check("id_imm_ext", id_imm_ext, {{16{m_instr[15]}}, m_instr[15:0]});
        check("stall", {31'b0, stall}, {31'b0, e_stall});
        check("flush", {31'b0, flush}, {31'b0, e_flush});
        check("ctrl_bubble", {31'b0, ctrl_bubble}, {31'b0, e_bubble});
        check("idex_muxcond", {26'b0, idex_muxcond}, {26'b0, e_muxcond});
`ifdef IF_ID_HAZARD_STATS_EN
        check("stall_count", stall_count, m_stalls);
        check("flush_count", flush_count, m_flushes);
`endif
    endtask

    task automatic drive(input logic hold, input logic jump, input logic [31:0] target,
                         input logic memread, input logic [4:0] rt);
        ext_hold = hold; ex_jump = jump; ex_jump_target = target;
        ex_memread = memread; ex_rt = rt;
    endtask

    // Called at a falling edge with inputs applied; returns at the next falling edge.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 5'd0);
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic fill_imem();
        logic [31:0] r;
        for (int i = 0; i < 256; i++) begin
            r = $urandom();
            imem[i] = {r[31:26], 2'b00, r[23:21], 2'b00, r[18:16], r[15:0]};
        end
    endtask

    initial begin
        w_zero = 1'b0; w_zero32 = 32'h0; w_zero5 = 5'd0;
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 5'd0);
        fill_imem();
        @(negedge clk);

        // Reset values and free run from 0
        do_reset();
        check("reset_bubble", {31'b0, ctrl_bubble}, 32'd1);
        check("wrap_reset_addr", imem_w.imem_addr, 32'hFFFF_FFFC);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        for (int i = 0; i < 3; i++) begin
            check("fetch_seq", imem_bus.imem_addr, exp_q.pop_front());
            tick();
            if (i == 0) begin
                check("first_pc4", ifid_pc4, 32'h4);
                check("first_valid", {31'b0, ifid_valid}, 32'd1);
                check("first_bubble", {31'b0, ctrl_bubble}, 32'd0);
                check("wrap_addr", imem_w.imem_addr, 32'h0);
                check("wrap_pc4", w_pc4, 32'h0);
            end
        end

        // Load-use on add $3,$5,$6, then rt=0 never stalls
        imem[0] = 32'h00A6_1820;
        imem[1] = 32'h0000_1020;
        do_reset();
        tick();
        drive(0, 0, 32'h0, 1, 5'd5);
        #1;
        check("lu_stall", {31'b0, stall}, 32'd1);
        check("lu_bubble", {31'b0, ctrl_bubble}, 32'd1);
        check("lu_muxcond", {26'b0, idex_muxcond}, 32'd1);
        check("lu_addr", imem_bus.imem_addr, 32'h4);
        tick();
        check("lu_addr_held", imem_bus.imem_addr, 32'h4);
`ifdef IF_ID_HAZARD_STATS_EN
        check("lu_stall_count", stall_count, 32'd1);
`endif
        drive(0, 0, 32'h0, 0, 5'd0);
        #1;
        check("lu_stall_cleared", {31'b0, stall}, 32'd0);
        tick();
        drive(0, 0, 32'h0, 1, 5'd0);
        #1;
        check("rt0_no_stall", {31'b0, stall}, 32'd0);
        tick();

        // Jump and hazard together: squash wins
        do_reset();
        tick();
        drive(0, 1, 32'h40, 1, 5'd5);
        #1;
        check("jh_flush", {31'b0, flush}, 32'd1);
        check("jh_stall", {31'b0, stall}, 32'd0);
        tick();
        check("jh_addr", imem_bus.imem_addr, 32'h40);
        check("jh_valid", {31'b0, ifid_valid}, 32'd0);
        drive(0, 0, 32'h0, 0, 5'd0);
        tick();
        check("jh_target_pc4", ifid_pc4, 32'h44);

        // ext_hold during a hazard, then the stall resumes
        do_reset();
        tick();
        drive(1, 0, 32'h0, 1, 5'd5);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_muxcond", {26'b0, idex_muxcond}, 32'd0);
            check("hold_stall", {31'b0, stall}, 32'd0);
            check("hold_addr", imem_bus.imem_addr, 32'h4);
            tick();
        end
        drive(0, 0, 32'h0, 1, 5'd5);
        #1;
        check("hold_release_stall", {31'b0, stall}, 32'd1);
        tick();
        drive(0, 0, 32'h0, 0, 5'd0);
        tick();

        // Randomized traffic against the model, with occasional mid-run resets
        fill_imem();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            if ((i % 150) == 149) begin
                do_reset();
                continue;
            end
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, tgt,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
